// File: rtl/kernel_ram_responder.sv
// Scratch-RAM responder for a streaming kernel: fixed-latency word store with byte-masked
// kernel writes, a single-entry pending slot, and a host preload/readout port.
module kernel_ram_responder #(
    parameter int DEPTH_LOG2 = 11,
    parameter int BASE       = 0,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [29:0]           k_addr,
    input  logic [31:0]           k_wdata,
    input  logic [3:0]            k_mask,
    input  logic                  k_we,
    input  logic                  k_re,
    output logic [31:0]           k_rdata,
    output logic                  k_ready,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [DEPTH_LOG2-1:0] h_addr,
    input  logic [31:0]           h_wdata,
    output logic [31:0]           h_rdata,
    output logic                  h_ack,
    output logic                  err_oob,
    output logic                  err_proto,
    output logic                  busy
);
    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [30:0] BASE_W   = 31'(BASE);

    typedef enum logic [1:0] {IDLE, K_WAIT, H_WAIT} state_t;

    logic [31:0] mem [DEPTH];

    state_t state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        p_valid, p_valid_n, p_we, p_we_n;
    logic [29:0] p_addr, p_addr_n;
    logic [31:0] p_wdata, p_wdata_n;
    logic [3:0]  p_mask, p_mask_n;
    logic        c_we, c_we_n;
    logic [29:0] c_addr, c_addr_n;
    logic [31:0] c_wdata, c_wdata_n;
    logic [3:0]  c_mask, c_mask_n;
    logic        hc_we, hc_we_n;
    logic [DEPTH_LOG2-1:0] hc_idx, hc_idx_n;
    logic [31:0] hc_wdata, hc_wdata_n;
    logic        k_ready_n, h_ack_n, err_oob_n, err_proto_n;
    logic [31:0] k_rdata_n, h_rdata_n;

    logic        k_pulse, viol, accept, k_oob;
    logic [30:0] diff;
    logic [DEPTH_LOG2-1:0] k_idx;
    logic        mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;

    // Borrow in bit 30 catches addresses below BASE; upper bits catch the top end.
    assign diff  = {1'b0, c_addr} - BASE_W;
    assign k_oob = diff[30] | (diff[29:DEPTH_LOG2] != '0);
    assign k_idx = diff[DEPTH_LOG2-1:0];

    assign k_pulse = k_re ^ k_we;
    assign viol    = (k_re & k_we) | (k_pulse & (p_valid | (state == K_WAIT)));
    assign accept  = k_pulse & ~viol;
    assign busy    = (state != IDLE) | p_valid;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        p_valid_n   = p_valid;
        p_we_n      = p_we;
        p_addr_n    = p_addr;
        p_wdata_n   = p_wdata;
        p_mask_n    = p_mask;
        c_we_n      = c_we;
        c_addr_n    = c_addr;
        c_wdata_n   = c_wdata;
        c_mask_n    = c_mask;
        hc_we_n     = hc_we;
        hc_idx_n    = hc_idx;
        hc_wdata_n  = hc_wdata;
        k_ready_n   = k_ready;
        k_rdata_n   = k_rdata;
        h_rdata_n   = h_rdata;
        h_ack_n     = 1'b0;
        err_oob_n   = err_oob;
        err_proto_n = err_proto | viol;
        mem_we      = 1'b0;
        mem_idx     = k_idx;
        mem_data    = c_wdata;
        mem_be      = c_mask;

        if (accept) begin
            p_valid_n = 1'b1;
            p_we_n    = k_we;
            p_addr_n  = k_addr;
            p_wdata_n = k_wdata;
            p_mask_n  = k_mask;
            k_ready_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (p_valid | accept) begin
                    state_n   = K_WAIT;
                    cnt_n     = CNT_INIT;
                    p_valid_n = 1'b0;
                    c_we_n    = p_valid ? p_we    : k_we;
                    c_addr_n  = p_valid ? p_addr  : k_addr;
                    c_wdata_n = p_valid ? p_wdata : k_wdata;
                    c_mask_n  = p_valid ? p_mask  : k_mask;
                end else if (h_req & ~h_ack) begin
                    // h_ack still high means this h_req is the one just served.
                    state_n    = H_WAIT;
                    cnt_n      = CNT_INIT;
                    hc_we_n    = h_we;
                    hc_idx_n   = h_addr;
                    hc_wdata_n = h_wdata;
                end
            end
            K_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    state_n   = IDLE;
                    k_ready_n = 1'b1;
                    if (k_oob) err_oob_n = 1'b1;
                    if (c_we) mem_we = ~k_oob;
                    else      k_rdata_n = k_oob ? 32'd0 : mem[k_idx];
                end
            end
            H_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    state_n  = IDLE;
                    h_ack_n  = 1'b1;
                    mem_idx  = hc_idx;
                    mem_data = hc_wdata;
                    mem_be   = 4'b1111;
                    if (hc_we) mem_we = 1'b1;
                    else       h_rdata_n = mem[hc_idx];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            p_valid   <= 1'b0;
            k_ready   <= 1'b1;
            k_rdata   <= 32'd0;
            h_rdata   <= 32'd0;
            h_ack     <= 1'b0;
            err_oob   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            p_valid   <= p_valid_n;
            p_we      <= p_we_n;
            p_addr    <= p_addr_n;
            p_wdata   <= p_wdata_n;
            p_mask    <= p_mask_n;
            c_we      <= c_we_n;
            c_addr    <= c_addr_n;
            c_wdata   <= c_wdata_n;
            c_mask    <= c_mask_n;
            hc_we     <= hc_we_n;
            hc_idx    <= hc_idx_n;
            hc_wdata  <= hc_wdata_n;
            k_ready   <= k_ready_n;
            k_rdata   <= k_rdata_n;
            h_rdata   <= h_rdata_n;
            h_ack     <= h_ack_n;
            err_oob   <= err_oob_n;
            err_proto <= err_proto_n;
        end
    end

    // Store is never cleared; reset only suppresses an uncommitted write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_kernel_ram_responder.sv
// Directed bench for kernel_ram_responder: drivers push expected read data into queues,
// a negedge monitor pops and compares on each kernel completion and each h_ack.
module tb_kernel_ram_responder;
    localparam int DEPTH_LOG2 = 11;
    localparam int LAT        = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] k_addr = '0;
    logic [31:0] k_wdata = '0;
    logic [3:0]  k_mask = '0;
    logic        k_we = 1'b0, k_re = 1'b0;
    logic [31:0] k_rdata;
    logic        k_ready;
    logic        h_req = 1'b0, h_we = 1'b0;
    logic [DEPTH_LOG2-1:0] h_addr = '0;
    logic [31:0] h_wdata = '0;
    logic [31:0] h_rdata;
    logic        h_ack, err_oob, err_proto, busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] k_exp_q[$];
    logic [31:0] h_exp_q[$];
    logic        prev_ready = 1'b1, prev_rst = 1'b1, saw_hack = 1'b0;

    kernel_ram_responder #(.DEPTH_LOG2(DEPTH_LOG2), .BASE(0), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .k_addr(k_addr), .k_wdata(k_wdata), .k_mask(k_mask),
        .k_we(k_we), .k_re(k_re), .k_rdata(k_rdata), .k_ready(k_ready),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_ack(h_ack), .err_oob(err_oob), .err_proto(err_proto),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a k_ready rise not caused by reset marks a kernel completion.
    always @(negedge clk) begin
        if (k_ready && !prev_ready && !prev_rst) begin
            if (k_exp_q.size() == 0) check("k_unexpected_completion", 32'd1, 32'd0);
            else check("k_rdata", k_rdata, k_exp_q.pop_front());
        end
        if (h_ack) begin
            saw_hack = 1'b1;
            if (h_exp_q.size() == 0) check("h_unexpected_ack", 32'd1, 32'd0);
            else check("h_rdata", h_rdata, h_exp_q.pop_front());
        end
        prev_ready = k_ready;
        prev_rst   = rst;
    end

    task automatic k_pulse(input logic we, input logic [29:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic [31:0] exp);
        k_exp_q.push_back(exp);
        @(negedge clk);
        k_we = we; k_re = ~we; k_addr = addr; k_wdata = data; k_mask = mask;
        @(negedge clk);
        k_we = 1'b0; k_re = 1'b0;
    endtask

    task automatic wait_ready(output int low);
        low = 1;
        while (!k_ready && low < 100) begin
            @(negedge clk);
            if (!k_ready) low++;
        end
        if (!k_ready) check("k_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic kernel_op(input logic we, input logic [29:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input logic [31:0] exp, input string name);
        int low;
        k_pulse(we, addr, data, mask, exp);
        check({name, "_ready_low"}, {31'd0, k_ready}, 32'd0);
        wait_ready(low);
        check({name, "_latency"}, 32'(low), 32'(LAT));
    endtask

    task automatic host_op(input logic we, input logic [DEPTH_LOG2-1:0] addr,
                           input logic [31:0] data, input logic [31:0] exp);
        int n;
        h_exp_q.push_back(exp);
        @(negedge clk);
        h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!h_ack && n < 100);
        if (!h_ack) check("h_ack_timeout", 32'd0, 32'd1);
        h_req = 1'b0;
    endtask

    initial begin
        int low, n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_k_ready", {31'd0, k_ready}, 32'd1);
        check("rst_k_rdata", k_rdata, 32'd0);
        check("rst_h_rdata", h_rdata, 32'd0);
        check("rst_flags", {28'd0, h_ack, err_oob, err_proto, busy}, 32'd0);

        // Full write then readback, latency measured on both.
        kernel_op(1'b1, 30'd5, 32'hDEADBEEF, 4'b1111, 32'd0, "t1_wr");
        kernel_op(1'b0, 30'd5, 32'd0, 4'b0000, 32'hDEADBEEF, "t1_rd");
        // Byte-masked merge.
        kernel_op(1'b1, 30'd5, 32'h11223344, 4'b0101, 32'hDEADBEEF, "t2_wr");
        kernel_op(1'b0, 30'd5, 32'd0, 4'b1111, 32'hDE22BE44, "t2_rd");

        // Simultaneous kernel read and host write: kernel first, host ack LAT+1 later.
        fork
            host_op(1'b1, 11'd7, 32'hCAFEF00D, 32'd0);
            begin
                kernel_op(1'b0, 30'd5, 32'd0, 4'b0000, 32'hDE22BE44, "t3_rd");
                n = 0;
                while (!h_ack && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("t3_hack_delay", 32'(n), 32'(LAT + 1));
            end
        join
        host_op(1'b0, 11'd7, 32'd0, 32'hCAFEF00D);
        host_op(1'b1, 11'd0, 32'h01020304, 32'hCAFEF00D);

        // Kernel pulse while the host op is in flight is queued behind it.
        saw_hack = 1'b0;
        fork
            host_op(1'b0, 11'd7, 32'd0, 32'hCAFEF00D);
            begin
                @(negedge clk);
                k_pulse(1'b0, 30'd0, 32'd0, 4'b0000, 32'h01020304);
                check("t4_ready_low", {31'd0, k_ready}, 32'd0);
                wait_ready(low);
                check("t4_after_hack", {31'd0, saw_hack}, 32'd1);
                check("t4_err_proto", {31'd0, err_proto}, 32'd0);
            end
        join

        // Out-of-range accesses.
        kernel_op(1'b1, 30'd2048, 32'hFFFFFFFF, 4'b1111, 32'h01020304, "t5_wr_oob");
        check("t5_err_oob", {31'd0, err_oob}, 32'd1);
        kernel_op(1'b0, 30'd0, 32'd0, 4'b0000, 32'h01020304, "t5_rd0");
        kernel_op(1'b0, 30'd2048, 32'd0, 4'b0000, 32'd0, "t5_rd_oob");

        // Second pulse while busy is dropped and flagged.
        k_pulse(1'b0, 30'd5, 32'd0, 4'b0000, 32'hDE22BE44);
        k_re = 1'b1; k_addr = 30'd7;
        @(negedge clk);
        k_re = 1'b0;
        check("t6_err_proto", {31'd0, err_proto}, 32'd1);
        wait_ready(low);

        // Reset during K_WAIT aborts an uncommitted write.
        @(negedge clk);
        k_we = 1'b1; k_addr = 30'd5; k_wdata = 32'h0; k_mask = 4'b1111;
        @(negedge clk);
        k_we = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_k_ready", {31'd0, k_ready}, 32'd1);
        check("t6_rst_flags", {29'd0, err_oob, err_proto, busy}, 32'd0);
        check("t6_rst_k_rdata", k_rdata, 32'd0);
        kernel_op(1'b0, 30'd5, 32'd0, 4'b0000, 32'hDE22BE44, "t6_rd_after_rst");

        repeat (3) @(negedge clk);
        check("k_queue_drained", 32'(k_exp_q.size()), 32'd0);
        check("h_queue_drained", 32'(h_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
